// File: rtl/cordic_sequencer.sv
// Control FSM for the iterative 12-bit CORDIC datapath: one load cycle, ITERATIONS micro-rotations, done pulse.
// Optional macro CORDIC_VECTOR_EN adds a vectoring mode (mode port, Delta_B steered by y_msb).
module cordic_sequencer #(
  parameter int ITERATIONS = 12,
  parameter int WIDTH      = 12
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             req,
  input  logic             theta_msb,
  input  logic             y_msb,
`ifdef CORDIC_VECTOR_EN
  input  logic             mode,
`endif
  output logic             Start,
  output logic             Enable,
  output logic [3:0]       Count,
  output logic             Delta_B,
  output logic [WIDTH-1:0] Theta_i,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  // Handshake: req is a level sampled on a rising edge only while IDLE; anything
  // seen in LOAD/ITER/DONE is dropped, never queued. done is a single-cycle pulse.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

  state_t     state, state_next;
  logic [3:0] count_q, count_next;
  logic       dir;

  // arctan(2^-i) in units of 4096 per turn
  function automatic logic [WIDTH-1:0] lut(input logic [3:0] idx);
    logic [11:0] v;
    case (idx)
      4'd0:    v = 12'd512;
      4'd1:    v = 12'd302;
      4'd2:    v = 12'd160;
      4'd3:    v = 12'd81;
      4'd4:    v = 12'd41;
      4'd5:    v = 12'd20;
      4'd6:    v = 12'd10;
      4'd7:    v = 12'd5;
      4'd8:    v = 12'd3;
      4'd9:    v = 12'd1;
      4'd10:   v = 12'd1;
      default: v = 12'd0;
    endcase
    return WIDTH'(v);
  endfunction

`ifdef CORDIC_VECTOR_EN
  logic mode_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      mode_q <= 1'b0;
    end else if (state == IDLE && req) begin
      mode_q <= mode;
    end
  end

  // Vectoring drives Y toward zero: positive Y means rotate clockwise.
  assign dir = mode_q ? ~y_msb : theta_msb;
`else
  logic unused_y;
  assign unused_y = y_msb;
  assign dir      = theta_msb;
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      count_q <= 4'd0;
    end else begin
      state   <= state_next;
      count_q <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = 4'd0;
    Start      = 1'b0;
    Enable     = 1'b0;
    Count      = 4'd0;
    Delta_B    = 1'b0;
    Theta_i    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_next = LOAD;
      end
      LOAD: begin
        Start      = 1'b1;
        Enable     = 1'b1;
        busy       = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        Enable  = 1'b1;
        busy    = 1'b1;
        Count   = count_q;
        Theta_i = lut(count_q);
        Delta_B = dir;
        if (count_q == LAST) begin
          state_next = DONE;
        end else begin
          count_next = count_q + 4'd1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: a cycle-position model of one conversion checked every cycle,
// directed scenarios with literal timing/LUT expectations, then randomized traffic.
module tb_cordic_sequencer;
  localparam int N = 12;
  localparam int W = 12;

  logic         CLK;
  logic         CLR;
  logic         req;
  logic         theta_msb;
  logic         y_msb;
  logic         mode;
  logic         Start;
  logic         Enable;
  logic [3:0]   Count;
  logic         Delta_B;
  logic [W-1:0] Theta_i;
  logic         busy;
  logic         done;
  logic [1:0]   fsm_state;

  cordic_sequencer #(.ITERATIONS(N), .WIDTH(W)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .req       (req),
    .theta_msb (theta_msb),
    .y_msb     (y_msb),
`ifdef CORDIC_VECTOR_EN
    .mode      (mode),
`endif
    .Start     (Start),
    .Enable    (Enable),
    .Count     (Count),
    .Delta_B   (Delta_B),
    .Theta_i   (Theta_i),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int done_cnt   = 0;
  int last_start = -1;
  int last_done  = -1;

  // model: phase = cycles since acceptance (0 = idle, 1 = load, 2..N+1 = iterate, N+2 = done)
  int   phase  = 0;
  logic mode_m = 1'b0;
  int   lut [12] = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_update();
    if (CLR) phase = 0;
    else if (phase == 0) begin
      if (req) begin
        phase  = 1;
        mode_m = mode;
      end
    end else if (phase == N + 2) phase = 0;
    else phase++;
  endtask

  // scoreboard compare of every output against the model
  task automatic check_cycle();
    logic in_iter;
    int   exp_dir;
    in_iter = (phase >= 2 && phase <= N + 1);
`ifdef CORDIC_VECTOR_EN
    exp_dir = mode_m ? int'(~y_msb) : int'(theta_msb);
`else
    exp_dir = int'(theta_msb);
`endif
    chk("Start",   Start,   phase == 1);
    chk("Enable",  Enable,  phase >= 1 && phase <= N + 1);
    chk("busy",    busy,    phase >= 1 && phase <= N + 1);
    chk("done",    done,    phase == N + 2);
    chk("Count",   Count,   in_iter ? phase - 2 : 0);
    chk("Theta_i", Theta_i, in_iter ? lut[phase - 2] : 0);
    chk("Delta_B", Delta_B, in_iter ? exp_dir : 0);
  endtask

  // driver: one clock, model advance, compare in the low phase
  task automatic step();
    @(posedge CLK);
    cyc++;
    model_update();
    @(negedge CLK);
    check_cycle();
    if (Start) last_start = cyc;
    if (done) begin
      done_cnt++;
      last_done = cyc;
    end
  endtask

  task automatic assert_clr_mid_cycle();
    #2 CLR = 1'b1;
    phase = 0;
    #1 check_cycle();
    chk("clr_state", fsm_state, 0);
  endtask

  initial begin
    int a;
    int rel;
    int d0;
    int first;
    int second;
    bit found;

    CLR = 1'b1; req = 1'b0; theta_msb = 1'b0; y_msb = 1'b0; mode = 1'b0;
    #1 check_cycle();
    chk("reset_state", fsm_state, 0);
    repeat (2) step();
    CLR = 1'b0;
    repeat (2) step();

    // single request: timing, LUT sequence
    req = 1'b1;
    step();
    a = cyc;
    req = 1'b0;
    d0 = done_cnt;
    chk("load_cycle", last_start - a + 1, 1);
    for (int i = 0; i < 14; i++) begin
      step();
      rel = cyc - a + 1;
      if (rel == 2) begin
        chk("count_first", Count, 0);
        chk("theta_first", Theta_i, 512);
      end
      if (rel == 5) chk("theta_idx3", Theta_i, 81);
      if (rel == 13) begin
        chk("count_last", Count, 11);
        chk("theta_last", Theta_i, 0);
      end
    end
    chk("done_cycle", last_done - a + 1, 14);
    chk("done_pulses", done_cnt - d0, 1);

    // direction follows theta_msb within the cycle
    req = 1'b1;
    step();
    req = 1'b0;
    repeat (4) step();
    theta_msb = 1'b1;
    #1 chk("delta_follow_1", Delta_B, 1);
    theta_msb = 1'b0;
    #1 chk("delta_follow_0", Delta_B, 0);
    repeat (12) step();

    // req held high: 15-cycle period, no extra done
    d0 = done_cnt;
    first = -1;
    second = -1;
    req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (Start) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
    end
    req = 1'b0;
    chk("req_period", second - first, 15);
    chk("held_done_pulses", done_cnt - d0, 2);
    repeat (16) step();

    // abort at Count==5
    d0 = done_cnt;
    req = 1'b1;
    step();
    req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        step();
        if (Enable && Count == 4'd5) found = 1'b1;
      end
    end
    chk("reach_count5", found, 1);
    assert_clr_mid_cycle();
    repeat (3) step();
    CLR = 1'b0;
    repeat (20) step();
    chk("abort_no_done", done_cnt - d0, 0);
    req = 1'b1;
    step();
    req = 1'b0;
    a = cyc;
    repeat (N + 2) step();
    chk("after_abort_done_cycle", last_done - a + 1, 14);

`ifdef CORDIC_VECTOR_EN
    // vectoring: Delta_B = ~y_msb, mode latched at acceptance
    mode = 1'b1; y_msb = 1'b0;
    req = 1'b1;
    step();
    req = 1'b0;
    mode = 1'b0;
    step();
    chk("vec_y0", Delta_B, 1);
    y_msb = 1'b1;
    #1 chk("vec_y1", Delta_B, 0);
    repeat (14) step();
`else
    // rotation only: y_msb ignored
    theta_msb = 1'b0; y_msb = 1'b1;
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk("rot_y1", Delta_B, 0);
    y_msb = 1'b0;
    #1 chk("rot_y0", Delta_B, 0);
    repeat (14) step();
`endif

    // randomized traffic with occasional aborts
    for (int i = 0; i < 800; i++) begin
      req       = ($urandom_range(0, 3) == 0);
      theta_msb = $urandom_range(0, 1);
      y_msb     = $urandom_range(0, 1);
      mode      = $urandom_range(0, 1);
      if (CLR) CLR = 1'b0;
      else if ($urandom_range(0, 199) == 0) begin
        CLR = 1'b1;
        phase = 0;
      end
      step();
    end
    CLR = 1'b0;
    req = 1'b0;
    repeat (N + 4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
